logic_unit_seq: RTL and testbench
=================================

# logic_unit_seq

Parametrised, registered successor to the two-input gate block. It computes the same gate functions (AND, NAND, OR, NOR, XOR, XNOR, NOT) bitwise on WIDTH-bit operands. A small FSM either evaluates one selected operation (single mode) or steps through all eight operation codes on latched operands (sweep mode), tagging each result with its op code. It serves as a self-checking logic-function source for datapath exercises and board-level demos.

## Interface

- WIDTH, 8, operand/result width in bits (≥1)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only when busy=0
- mode  input  1  0 = single op, 1 = sweep all ops; sampled with start
- op  input  3  operation code for single mode; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while an accepted request is in progress
- out_valid  output  1  one-cycle strobe, y/out_op hold a new result
- out_op  output  3  op code of the current y
- y  output  WIDTH  result
- done  output  1  one-cycle strobe on the last result of a request

## Operation

- Op codes (bitwise): 0 a&b, 1 ~(a&b), 2 a|b, 3 ~(a|b), 4 a^b, 5 ~(a^b), 6 ~a, 7 ~b.
- States: IDLE, SINGLE, SWEEP. busy = (state != IDLE).
- IDLE: start=1 latches a, b, op, mode into internal registers, then goes to SINGLE (mode=0) or SWEEP (mode=1, clear 3-bit step counter). start=0 stays IDLE.
- SINGLE: registers y=f(op_latched), out_op=op_latched, out_valid=1, done=1, then returns to IDLE.
- SWEEP: each cycle registers y=f(step), out_op=step, out_valid=1, then increments step. When step=7, also asserts done=1 and returns to IDLE. The counter does not wrap past 7 within a request.
- start while busy=1 is ignored (not queued). Input changes while busy do not affect results.
- start in the same cycle as done is accepted, because busy is already 0.
- y and out_op hold their last value when out_valid=0. out_valid and done are low in every other cycle.
- Reset, in any state: state=IDLE, busy=0, out_valid=0, done=0, y=0, out_op=0, latched operands and counter cleared. An aborted sweep produces no done.
- All outputs are registered; no combinational path from inputs to outputs.

## Timing

- Edge N samples start=1 with busy=0. busy=1 from just after edge N.
- Single: edge N+1 registers the result with out_valid=1 and done=1, and busy drops to 0. Latency is 1 cycle. Back-to-back requests are possible every 2 cycles.
- Sweep: edges N+1 through N+8 register ops 0 through 7, with out_valid=1 on 8 consecutive cycles. done=1 only with op 7 (edge N+8), and busy falls at edge N+8. busy is high for exactly 8 cycles.
- Reset asserts asynchronously: outputs clear immediately, without waiting for a clock edge. Deassertion is synchronous to the design's clock domain: the first start is sampled on the first rising edge after reset is low.

## Test plan

- Reset: drive reset=1 mid-run, then release -> busy=0, out_valid=0, done=0, y=0, out_op=0, held until start.
- Single mode, WIDTH=8, a=8'hF0, b=8'hCC, op=4 -> one cycle later out_valid=1, done=1, out_op=4, y=8'h3C, busy high for exactly 1 cycle.
- Sweep, a=8'hF0, b=8'hCC -> 8 consecutive valid cycles with (out_op, y) = (0,C0) (1,3F) (2,FC) (3,03) (4,3C) (5,C3) (6,0F) (7,33), and done only on op 7.
- Start while busy: second start with a=8'hFF during the sweep -> ignored, and the sweep results still match a=8'hF0. Then start in the done cycle with mode=0, op=0, a=8'hAA, b=8'h0F -> accepted, giving y=8'h0A next cycle.
- Reset mid-sweep: assert reset after the op-3 result -> outputs clear immediately, no further out_valid, no done. After release, a new single request works normally.
- Width check: WIDTH=1, sweep with a=1, b=0 -> y sequence 0,1,1,0,1,0,0,1.

Source files
------------

// File: rtl/logic_unit_seq.sv
// logic_unit_seq: registered bitwise gate unit with single-op and eight-op sweep modes
module logic_unit_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             out_valid,
    output logic [2:0]       out_op,
    output logic [WIDTH-1:0] y,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, SINGLE, SWEEP} state_t;
    state_t state, next_state;
    logic [WIDTH-1:0] a_r, b_r;
    logic [2:0] op_r, step, sel;
    logic last;
    function automatic logic [WIDTH-1:0] gate(input logic [2:0] k, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] z);
        case (k)
            3'd0: gate = x & z;
            3'd1: gate = ~(x & z);
            3'd2: gate = x | z;
            3'd3: gate = ~(x | z);
            3'd4: gate = x ^ z;
            3'd5: gate = ~(x ^ z);
            3'd6: gate = ~x;
            default: gate = ~z;
        endcase
    endfunction
    assign busy = (state != IDLE);
    assign sel  = (state == SWEEP) ? step : op_r;
    assign last = (state == SINGLE) || (state == SWEEP && step == 3'd7);
    always_comb begin
        next_state = state;
        next_state = (state == IDLE) ? (start ? (mode ? SWEEP : SINGLE) : IDLE) :
                     (state == SWEEP && step != 3'd7) ? SWEEP : IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r       <= '0;
            b_r       <= '0;
            op_r      <= '0;
            step      <= '0;
            y         <= '0;
            out_op    <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            out_valid <= busy;
            done      <= last;
            if (state == IDLE && start) begin
                a_r  <= a;
                b_r  <= b;
                op_r <= op;
                step <= '0;
            end
            if (busy) begin
                y      <= gate(sel, a_r, b_r);
                out_op <= sel;
            end
            if (state == SWEEP) step <= step + 3'd1;
        end
    end
endmodule

// File: tb/tb_logic_unit_seq.sv
// tb_logic_unit_seq: table-driven, hand-sequenced and randomized checks against a behavioural model
module tb_logic_unit_seq;
    logic clk = 1'b0;
    logic reset, start, mode;
    logic [2:0] op;
    logic [7:0] a, b;
    logic busy, out_valid, done;
    logic [2:0] out_op;
    logic [7:0] y;
    logic start1, mode1;
    logic [2:0] op1;
    logic [0:0] a1, b1, y1;
    logic busy1, out_valid1, done1;
    logic [2:0] out_op1;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
    } vec_t;
    typedef struct {
        logic [2:0] op;
        logic [7:0] y;
    } res_t;
    vec_t singles[6];
    logic [7:0] sweep_exp[8];
    logic [7:0] w1_exp;
    res_t q[$];

    logic_unit_seq #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .op(op), .a(a), .b(b),
        .busy(busy), .out_valid(out_valid), .out_op(out_op), .y(y), .done(done)
    );
    logic_unit_seq #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .mode(mode1), .op(op1), .a(a1), .b(b1),
        .busy(busy1), .out_valid(out_valid1), .out_op(out_op1), .y(y1), .done(done1)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    function automatic logic [7:0] ref_f(input int k, input logic [7:0] x, input logic [7:0] z);
        case (k)
            0: return x & z;
            1: return ~(x & z);
            2: return x | z;
            3: return ~(x | z);
            4: return x ^ z;
            5: return ~(x ^ z);
            6: return ~x;
            default: return ~z;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, " busy"}, 32'(busy), 0);
        chk({name, " out_valid"}, 32'(out_valid), 0);
        chk({name, " done"}, 32'(done), 0);
        chk({name, " y"}, 32'(y), 0);
        chk({name, " out_op"}, 32'(out_op), 0);
    endtask

    task automatic do_single(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z, input logic [7:0] ey);
        @(negedge clk);
        chk("single pre busy", 32'(busy), 0);
        start = 1'b1; mode = 1'b0; op = o; a = x; b = z;
        @(negedge clk);
        start = 1'b0; a = ~x; b = ~z; op = ~o;
        chk("single busy", 32'(busy), 1);
        chk("single early valid", 32'(out_valid), 0);
        @(negedge clk);
        chk("single valid", 32'(out_valid), 1);
        chk("single done", 32'(done), 1);
        chk("single out_op", 32'(out_op), 32'(o));
        chk("single y", 32'(y), 32'(ey));
        chk("single busy drop", 32'(busy), 0);
    endtask

    initial begin
        singles[0] = '{3'd4, 8'hF0, 8'hCC, 8'h3C};
        singles[1] = '{3'd0, 8'hAA, 8'h0F, 8'h0A};
        singles[2] = '{3'd2, 8'h12, 8'h34, 8'h36};
        singles[3] = '{3'd7, 8'h00, 8'h5A, 8'hA5};
        singles[4] = '{3'd6, 8'hFF, 8'h00, 8'h00};
        singles[5] = '{3'd1, 8'hFF, 8'hFF, 8'h00};
        sweep_exp = '{8'hC0, 8'h3F, 8'hFC, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'h33};
        w1_exp = 8'b1001_0110;
        reset = 1'b1; start = 1'b0; mode = 1'b0; op = '0; a = '0; b = '0;
        start1 = 1'b0; mode1 = 1'b0; op1 = '0; a1 = '0; b1 = '0;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        reset = 1'b0;
        @(negedge clk);
        chk_idle("post reset");
        foreach (singles[i]) do_single(singles[i].op, singles[i].a, singles[i].b, singles[i].y);

        // sweep with an ignored start during busy, then a start in the done cycle
        @(negedge clk);
        start = 1'b1; mode = 1'b1; a = 8'hF0; b = 8'hCC;
        @(negedge clk);
        chk("sweep busy", 32'(busy), 1);
        chk("sweep early valid", 32'(out_valid), 0);
        start = 1'b1; a = 8'hFF; b = 8'h00;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("sweep valid", 32'(out_valid), 1);
            chk("sweep out_op", 32'(out_op), 32'(k));
            chk("sweep y", 32'(y), 32'(sweep_exp[k]));
            chk("sweep done", 32'(done), 32'(k == 7));
            chk("sweep busy", 32'(busy), 32'(k != 7));
            if (k == 7) begin
                start = 1'b1; mode = 1'b0; op = 3'd0; a = 8'hAA; b = 8'h0F;
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk("done-cycle start busy", 32'(busy), 1);
        chk("done-cycle start valid", 32'(out_valid), 0);
        @(negedge clk);
        chk("done-cycle start valid", 32'(out_valid), 1);
        chk("done-cycle start y", 32'(y), 32'h0A);
        chk("done-cycle start done", 32'(done), 1);

        // reset mid-sweep after the op-3 result
        @(negedge clk);
        start = 1'b1; mode = 1'b1; a = 8'hF0; b = 8'hCC;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort sweep y", 32'(y), 32'(sweep_exp[k]));
        end
        #1 reset = 1'b1;
        #1 chk_idle("async reset");
        repeat (3) begin
            @(negedge clk);
            chk("reset hold valid", 32'(out_valid), 0);
            chk("reset hold done", 32'(done), 0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk_idle("after abort");
        do_single(3'd2, 8'h0F, 8'hF0, 8'hFF);

        // WIDTH=1 sweep
        @(negedge clk);
        start1 = 1'b1; mode1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
        @(negedge clk);
        start1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("w1 valid", 32'(out_valid1), 1);
            chk("w1 y", 32'(y1), 32'(w1_exp[k]));
            chk("w1 done", 32'(done1), 32'(k == 7));
        end

        // randomized requests with junk start/operand activity while busy
        for (int r = 0; r < 60; r++) begin
            logic [7:0] ra, rb;
            logic [2:0] ro;
            logic rm;
            int c;
            ra = 8'($urandom); rb = 8'($urandom); ro = 3'($urandom); rm = 1'($urandom);
            @(negedge clk);
            chk("rand pre busy", 32'(busy), 0);
            start = 1'b1; mode = rm; op = ro; a = ra; b = rb;
            q.delete();
            if (rm) for (int k = 0; k < 8; k++) q.push_back('{3'(k), ref_f(k, ra, rb)});
            else q.push_back('{ro, ref_f(int'(ro), ra, rb)});
            c = 0;
            while (q.size() > 0 && c < 12) begin
                @(negedge clk);
                c++;
                if (out_valid) begin
                    res_t e;
                    e = q.pop_front();
                    chk("rand out_op", 32'(out_op), 32'(e.op));
                    chk("rand y", 32'(y), 32'(e.y));
                    chk("rand done", 32'(done), 32'(q.size() == 0));
                end else begin
                    chk("rand idle done", 32'(done), 0);
                end
                chk("rand busy", 32'(busy), 32'(q.size() != 0));
                start = (q.size() != 0) ? 1'($urandom) : 1'b0;
                mode = 1'($urandom); op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
            end
            chk("rand pending results", q.size(), 0);
            start = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
